// File: rtl/branch_predictor_gshare.sv
// Branch predictor for the IF stage: tagged direct-mapped BTB plus a PHT of
// saturating counters, indexed bimodally or gshare-style.
module branch_predictor_gshare #(
    parameter int unsigned BTB_IDX_W = 4,
    parameter int unsigned PHT_IDX_W = 6,
    parameter int unsigned GHR_W     = 6,
    parameter int unsigned CNT_W     = 2,
    parameter bit          GSHARE    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc_i,
    output logic              pred_taken_o,
    output logic              pred_hit_o,
    output logic [31:0]       pred_target_o,
    input  logic              fb_valid_i,
    input  logic [31:0]       fb_pc_i,
    input  logic              fb_taken_i,
    input  logic [31:0]       fb_target_i,
    input  logic              fb_mispredict_i,
    output logic [GHR_W-1:0]  ghr_o,
    output logic [15:0]       mispredict_cnt_o
);

    localparam int unsigned BTB_N = 1 << BTB_IDX_W;
    localparam int unsigned PHT_N = 1 << PHT_IDX_W;
    localparam int unsigned TAG_W = 31 - BTB_IDX_W;
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [BTB_N-1:0]     btb_valid_q;
    logic [TAG_W-1:0]     btb_tag_q    [BTB_N];
    logic [30:0]          btb_target_q [BTB_N];
    logic [CNT_W-1:0]     pht_q        [PHT_N];
    logic [GHR_W-1:0]     ghr_q, ghr_d;
    logic [15:0]          mcnt_q, mcnt_d;

    logic [BTB_IDX_W-1:0] rd_btb_idx, wr_btb_idx;
    logic [TAG_W-1:0]     rd_tag, wr_tag;
    logic [PHT_IDX_W-1:0] rd_pht_idx, wr_pht_idx;
    logic [CNT_W-1:0]     cnt_old, cnt_d;
    logic                 unused_ok;

    // Same history is applied to lookup and update, each with its own PC.
    function automatic logic [PHT_IDX_W-1:0] pht_index(input logic [PHT_IDX_W-1:0] base,
                                                       input logic [GHR_W-1:0]     ghr);
        if (GSHARE) return base ^ PHT_IDX_W'(ghr);
        return base;
    endfunction

    assign rd_btb_idx = pc_i[BTB_IDX_W:1];
    assign rd_tag     = pc_i[31:BTB_IDX_W+1];
    assign rd_pht_idx = pht_index(pc_i[PHT_IDX_W:1], ghr_q);
    assign wr_btb_idx = fb_pc_i[BTB_IDX_W:1];
    assign wr_tag     = fb_pc_i[31:BTB_IDX_W+1];
    assign wr_pht_idx = pht_index(fb_pc_i[PHT_IDX_W:1], ghr_q);
    assign unused_ok  = ^{pc_i[0], fb_pc_i[0], fb_target_i[0]};

    // Zero-latency lookup; valid gates the unreset tag/target storage.
    assign pred_hit_o    = btb_valid_q[rd_btb_idx] && (btb_tag_q[rd_btb_idx] == rd_tag);
    assign pred_taken_o  = pred_hit_o && pht_q[rd_pht_idx][CNT_W-1];
    assign pred_target_o = pred_hit_o ? {btb_target_q[rd_btb_idx], 1'b0} : 32'h0;
    assign ghr_o            = ghr_q;
    assign mispredict_cnt_o = mcnt_q;

    always_comb begin
        cnt_old = pht_q[wr_pht_idx];
        cnt_d   = cnt_old;
        ghr_d   = ghr_q;
        mcnt_d  = mcnt_q;
        if (fb_taken_i) begin
            if (cnt_old != CNT_MAX) cnt_d = cnt_old + CNT_W'(1);
        end else if (cnt_old != '0) begin
            cnt_d = cnt_old - CNT_W'(1);
        end
        if (fb_valid_i) begin
            ghr_d = GHR_W'({ghr_q, fb_taken_i});
            if (fb_mispredict_i && (mcnt_q != 16'hFFFF)) mcnt_d = mcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid_q <= '0;
            for (int i = 0; i < int'(PHT_N); i++) pht_q[i] <= CNT_WNT;
            ghr_q  <= '0;
            mcnt_q <= '0;
        end else begin
            if (fb_valid_i) begin
                pht_q[wr_pht_idx] <= cnt_d;
                if (fb_taken_i) btb_valid_q[wr_btb_idx] <= 1'b1;
            end
            ghr_q  <= ghr_d;
            mcnt_q <= mcnt_d;
        end
    end

    // Tag/target need no reset: a cleared valid bit hides them.
    always_ff @(posedge clk) begin
        if (!rst && fb_valid_i && fb_taken_i) begin
            btb_tag_q[wr_btb_idx]    <= wr_tag;
            btb_target_q[wr_btb_idx] <= fb_target_i[31:1];
        end
    end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for branch_predictor_gshare: one bimodal and one gshare
// instance share stimulus; each test checks the instance it targets.
module tb_branch_predictor_gshare;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        fb_valid, fb_taken, fb_mispredict;
    logic [31:0] fb_pc, fb_target;

    logic        b_taken, b_hit, g_taken, g_hit;
    logic [31:0] b_target, g_target;
    logic [5:0]  b_ghr, g_ghr;
    logic [15:0] b_mcnt, g_mcnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    branch_predictor_gshare #(.GSHARE(1'b0)) u_bim (
        .clk(clk), .rst(rst), .pc_i(pc),
        .pred_taken_o(b_taken), .pred_hit_o(b_hit), .pred_target_o(b_target),
        .fb_valid_i(fb_valid), .fb_pc_i(fb_pc), .fb_taken_i(fb_taken),
        .fb_target_i(fb_target), .fb_mispredict_i(fb_mispredict),
        .ghr_o(b_ghr), .mispredict_cnt_o(b_mcnt)
    );

    branch_predictor_gshare #(.GSHARE(1'b1)) u_gsh (
        .clk(clk), .rst(rst), .pc_i(pc),
        .pred_taken_o(g_taken), .pred_hit_o(g_hit), .pred_target_o(g_target),
        .fb_valid_i(fb_valid), .fb_pc_i(fb_pc), .fb_taken_i(fb_taken),
        .fb_target_i(fb_target), .fb_mispredict_i(fb_mispredict),
        .ghr_o(g_ghr), .mispredict_cnt_o(g_mcnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fb_valid = 1'b0;
        fb_mispredict = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [31:0] p, input logic t, input logic [31:0] tgt,
                        input logic mp);
        fb_valid = 1'b1; fb_pc = p; fb_taken = t; fb_target = tgt; fb_mispredict = mp;
        tick();
        fb_valid = 1'b0; fb_mispredict = 1'b0;
    endtask

    // Any GHR state -> 6'b000110 via six updates from PC 0x42, whose PHT
    // indices never land on 6 and whose BTB slot (1) differs from 0x100's.
    task automatic restore_ghr6();
        send(32'h42, 1'b0, 32'h0, 1'b0);
        send(32'h42, 1'b0, 32'h0, 1'b0);
        send(32'h42, 1'b0, 32'h0, 1'b0);
        send(32'h42, 1'b1, 32'h500, 1'b0);
        send(32'h42, 1'b1, 32'h500, 1'b0);
        send(32'h42, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; pc = 32'h100; fb_valid = 1'b0; fb_taken = 1'b0;
        fb_mispredict = 1'b0; fb_pc = '0; fb_target = '0;
        #1;

        // Reset state
        do_reset();
        pc = 32'h100; #1;
        check("rst_hit",    32'(b_hit),    32'd0);
        check("rst_taken",  32'(b_taken),  32'd0);
        check("rst_target", b_target,      32'h0);
        check("rst_ghr",    32'(g_ghr),    32'd0);
        check("rst_mcnt",   32'(g_mcnt),   32'd0);
        check("rst_g_hit",  32'(g_hit),    32'd0);

        // Bimodal: single taken update allocates and predicts taken (1->2)
        send(32'h100, 1'b1, 32'h200, 1'b0);
        pc = 32'h100; #1;
        check("bim_hit",    32'(b_hit),   32'd1);
        check("bim_taken",  32'(b_taken), 32'd1);
        check("bim_target", b_target,     32'h200);

        // Saturation both ways
        do_reset();
        for (int i = 0; i < 5; i++) send(32'h100, 1'b1, 32'h200, 1'b0);
        send(32'h100, 1'b0, 32'h0, 1'b0);
        pc = 32'h100; #1;
        check("sat_hi_taken", 32'(b_taken), 32'd1);
        send(32'h100, 1'b0, 32'h0, 1'b0);
        send(32'h100, 1'b0, 32'h0, 1'b0);
        #1;
        check("sat_zero_taken", 32'(b_taken), 32'd0);
        check("sat_zero_hit",   32'(b_hit),   32'd1);
        check("nt_keeps_target", b_target,    32'h200);
        send(32'h100, 1'b0, 32'h0, 1'b0);
        send(32'h100, 1'b1, 32'h200, 1'b0);
        #1;
        check("sat_lo_taken", 32'(b_taken), 32'd0);

        // Tag conflict in BTB slot 0
        do_reset();
        send(32'h100, 1'b1, 32'h200, 1'b0);
        pc = 32'h120; #1;
        check("conf_miss_hit",   32'(b_hit),   32'd0);
        check("conf_miss_taken", 32'(b_taken), 32'd0);
        check("conf_miss_tgt",   b_target,     32'h0);
        send(32'h120, 1'b1, 32'h300, 1'b0);
        pc = 32'h100; #1;
        check("conf_old_hit", 32'(b_hit), 32'd0);
        pc = 32'h120; #1;
        check("conf_new_hit",    32'(b_hit),   32'd1);
        check("conf_new_target", b_target,     32'h300);
        check("conf_new_taken",  32'(b_taken), 32'd1);

        // Gshare history and indexing
        do_reset();
        send(32'h42, 1'b1, 32'h500, 1'b0);
        send(32'h42, 1'b1, 32'h500, 1'b0);
        send(32'h42, 1'b0, 32'h0, 1'b0);
        check("ghr_110",     32'(g_ghr), 32'h06);
        check("bim_ghr_110", 32'(b_ghr), 32'h06);
        pc = 32'h100; #1;
        check("gsh_cold_hit", 32'(g_hit), 32'd0);
        send(32'h100, 1'b1, 32'h200, 1'b0);
        pc = 32'h100; #1;
        check("gsh_ghr_0d",      32'(g_ghr),   32'h0D);
        check("gsh_hit",         32'(g_hit),   32'd1);
        check("gsh_off_taken",   32'(g_taken), 32'd0);
        check("bim_indep_taken", 32'(b_taken), 32'd1);
        restore_ghr6();
        pc = 32'h100; #1;
        check("gsh_ghr_back6", 32'(g_ghr),   32'h06);
        check("gsh_on_taken",  32'(g_taken), 32'd1);
        send(32'h100, 1'b1, 32'h200, 1'b0);
        #1;
        check("gsh_off2_taken", 32'(g_taken), 32'd0);
        restore_ghr6();
        #1;
        check("gsh_on2_taken", 32'(g_taken), 32'd1);

        // Lookup during its own first update sees pre-update state
        do_reset();
        pc = 32'h100;
        fb_valid = 1'b1; fb_pc = 32'h100; fb_taken = 1'b1; fb_target = 32'h200;
        fb_mispredict = 1'b0;
        #1;
        check("same_cyc_hit", 32'(b_hit), 32'd0);
        tick();
        fb_valid = 1'b0;
        #1;
        check("next_cyc_hit", 32'(b_hit), 32'd1);

        // Mispredict counting, gating by fb_valid_i, reset priority
        send(32'h100, 1'b1, 32'h200, 1'b1);
        send(32'h100, 1'b1, 32'h200, 1'b1);
        check("mcnt_two", 32'(b_mcnt), 32'd2);
        fb_mispredict = 1'b1;
        tick();
        fb_mispredict = 1'b0;
        check("mcnt_gated", 32'(b_mcnt), 32'd2);
        check("ghr_gated",  32'(b_ghr),  32'h07);
        rst = 1'b1;
        fb_valid = 1'b1; fb_pc = 32'h100; fb_taken = 1'b1; fb_target = 32'h200;
        fb_mispredict = 1'b1;
        tick();
        rst = 1'b0; fb_valid = 1'b0; fb_mispredict = 1'b0;
        pc = 32'h100; #1;
        check("rst2_hit",    32'(b_hit),   32'd0);
        check("rst2_taken",  32'(b_taken), 32'd0);
        check("rst2_target", b_target,     32'h0);
        check("rst2_ghr",    32'(b_ghr),   32'd0);
        check("rst2_mcnt",   32'(b_mcnt),  32'd0);
        check("rst2_g_hit",  32'(g_hit),   32'd0);

        // Counter saturation at 16'hFFFF
        fb_valid = 1'b1; fb_pc = 32'h80; fb_taken = 1'b0; fb_target = '0;
        fb_mispredict = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        check("mcnt_fffe", 32'(b_mcnt), 32'h0000FFFE);
        tick();
        check("mcnt_ffff", 32'(b_mcnt), 32'h0000FFFF);
        tick();
        fb_valid = 1'b0; fb_mispredict = 1'b0;
        check("mcnt_hold", 32'(b_mcnt), 32'h0000FFFF);
        check("mcnt_hold_g", 32'(g_mcnt), 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
